// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the chunk-serial adder/subtractor.
//   state_e     : controller states (idle, running chunks, result valid)
//   calc_nch    : number of chunk cycles per operation
//   calc_cnt_w  : chunk counter width, never below one bit
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned calc_nch(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice.
//   a_i, b_i : CHUNK-bit addends
//   c_i      : carry into bit 0
//   s_o      : CHUNK-bit sum
//   c_o      : carry out of the top bit
//   c_msb_o  : carry into the top bit (used for signed overflow on the last slice)
module chunk_adder #(
  parameter int unsigned Chunk = 4
) (
  input  logic [Chunk-1:0] a_i,
  input  logic [Chunk-1:0] b_i,
  input  logic             c_i,
  output logic [Chunk-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [Chunk:0] full;

  always_comb begin
    full    = {1'b0, a_i} + {1'b0, b_i} + {{Chunk{1'b0}}, c_i};
    s_o     = full[Chunk-1:0];
    c_o     = full[Chunk];
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
    c_msb_o = a_i[Chunk-1] ^ b_i[Chunk-1] ^ full[Chunk-1];
  end

endmodule

// File: rtl/serial_addsub.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per clock, LSB first,
// finishing a WIDTH-bit operation in WIDTH/CHUNK cycles.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : request an operation (ignored while busy)
//   a_i, b_i     : operands, latched on accepted start
//   ci_i         : carry-in for add (ignored for subtract)
//   sub_i        : 0 = add, 1 = subtract
//   busy_o       : operation in progress
//   done_o       : one-cycle pulse, result valid
//   sum_o        : result, held until the next accepted start
//   carry_o      : unsigned carry-out (add) / not-borrow (subtract)
//   overflow_o   : signed two's-complement overflow
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned NCH  = calc_nch(WIDTH, CHUNK);
  localparam int unsigned CntW = calc_cnt_w(NCH);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : gen_bad_chunk
    $error("serial_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;

  chunk_adder #(
    .Chunk (CHUNK)
  ) u_chunk_adder (
    .a_i     (a_q[CHUNK-1:0]),
    .b_i     (b_q[CHUNK-1:0]),
    .c_i     (c_q),
    .s_o     (slice_s),
    .c_o     (slice_co),
    .c_msb_o (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StRun;
          cnt_d   = '0;
          a_d     = a_i;
          // Subtract as a + ~b + 1: invert b up front and seed the carry with 1.
          b_d     = sub_i ? ~b_i : b_i;
          c_d     = sub_i ? 1'b1 : ci_i;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = slice_co;
        // New slice enters at the top; after NCH shifts slice 0 sits at bit 0.
        sum_d = (sum_q >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NCH - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
          carry_d = slice_co;
          ovf_d   = slice_cmsb ^ slice_co;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = (state_q == StRun);
  assign done_o     = (state_q == StDone);
  assign sum_o      = sum_q;
  assign carry_o    = carry_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: a 16/4 instance and an 8/8 instance,
// checked against an arithmetic reference model.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, 4-bit chunk instance
  logic        st16 = 1'b0, ci16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, c16, v16;
  logic [15:0] s16;

  // 8-bit, single-chunk instance
  logic        st8 = 1'b0, ci8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, c8, v8;
  logic [7:0]  s8;

  int checks = 0;
  int failures = 0;

  serial_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(st16), .a_i(a16), .b_i(b16), .ci_i(ci16),
    .sub_i(sub16), .busy_o(busy16), .done_o(done16), .sum_o(s16), .carry_o(c16),
    .overflow_o(v16)
  );

  serial_addsub #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(st8), .a_i(a8), .b_i(b8), .ci_i(ci8),
    .sub_i(sub8), .busy_o(busy8), .done_o(done8), .sum_o(s8), .carry_o(c8),
    .overflow_o(v8)
  );

  // Reference: plain integer arithmetic on w-bit values.
  function automatic void ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input bit ci, input bit sub, output logic [31:0] s,
                                 output bit c, output bit v);
    logic [63:0] mask;
    logic [63:0] full;
    mask = (64'd1 << w) - 64'd1;
    if (sub) begin
      full = ({32'd0, a} - {32'd0, b}) & mask;
      c    = (a >= b);
      s    = full[31:0];
      v    = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
    end else begin
      full = {32'd0, a} + {32'd0, b} + {63'd0, ci};
      c    = full[w];
      s    = full[31:0] & mask[31:0];
      v    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    end
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Start an op on the selected instance, scramble inputs while busy, measure latency
  // (edges from the accepting edge to done) and compare the result to the model.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input bit ci, input bit sub, input string name);
    logic [31:0] es, got_s;
    bit ec, ev;
    int lat;
    ref_op(w, a, b, ci, sub, es, ec, ev);
    @(negedge clk);
    if (w == 16) begin st16 = 1; a16 = a[15:0]; b16 = b[15:0]; ci16 = ci; sub16 = sub; end
    else begin st8 = 1; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; sub8 = sub; end
    @(posedge clk); #1;
    st16 = 0; st8 = 0;
    lat = 0;
    while (!(w == 16 ? done16 : done8) && lat < 20) begin
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); sub16 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    got_s = (w == 16) ? {16'd0, s16} : {24'd0, s8};
    checks++;
    if (lat !== (w == 16 ? 4 : 1)) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, (w == 16 ? 4 : 1));
    end
    checks++;
    if (got_s !== es) begin
      failures++;
      $display("FAIL %s sum: got %h expected %h", name, got_s, es);
    end
    check_bit({name, " carry"}, (w == 16) ? c16 : c8, ec);
    check_bit({name, " overflow"}, (w == 16) ? v16 : v8, ev);
    check_bit({name, " busy_at_done"}, (w == 16) ? busy16 : busy8, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    check_bit("reset busy", busy16, 1'b0);
    check_bit("reset done", done16, 1'b0);
    check_bit("reset carry", c16, 1'b0);
    check_bit("reset overflow", v16, 1'b0);
    checks++;
    if (s16 !== 16'h0) begin failures++; $display("FAIL reset sum: got %h expected 0000", s16); end
    // Start held high across release: must be accepted on the first rising edge.
    @(negedge clk);
    st16 = 1; a16 = 16'h0001; b16 = 16'h0002; ci16 = 0; sub16 = 0;
    rst_n = 1;
    @(posedge clk); #1;
    st16 = 0;
    check_bit("first_edge_accept busy", busy16, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (s16 !== 16'h0003) begin failures++; $display("FAIL first_op sum: got %h expected 0003", s16); end
  endtask

  task automatic test_directed();
    run_op(16, 32'h0000, 32'h8000, 0, 0, "d_msb");
    run_op(16, 32'hFFFF, 32'hFFFF, 1, 0, "d_allones");
    run_op(16, 32'h7FFF, 32'h0001, 0, 0, "d_ovf");
    run_op(16, 32'h0005, 32'h0007, 1, 1, "d_sub");
    // Done -> idle with no start: done drops, outputs held.
    @(posedge clk); #1;
    check_bit("hold done", done16, 1'b0);
    check_bit("hold busy", busy16, 1'b0);
    checks++;
    if (s16 !== 16'hFFFE) begin failures++; $display("FAIL hold sum: got %h expected fffe", s16); end
    check_bit("hold carry", c16, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(16, {16'd0, 16'($urandom)}, {16'd0, 16'($urandom)}, 1'($urandom), 1'($urandom),
             "rand16");
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    st16 = 1; a16 = 16'h1111; b16 = 16'h2222; ci16 = 1; sub16 = 0;
    @(posedge clk); #1;
    st16 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    st16 = 1; a16 = 16'h1234; b16 = 16'h4321; sub16 = 1;
    @(posedge clk); #1;
    st16 = 0;
    lat = 3;
    while (!done16 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ignore latency: got %0d expected 4", lat); end
    checks++;
    if (s16 !== 16'h3334) begin failures++; $display("FAIL ignore sum: got %h expected 3334", s16); end
    @(posedge clk); #1;
    check_bit("ignore no_restart busy", busy16, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(16, 32'h00F0, 32'h0F0F, 0, 0, "b2b_first");
    // Now in the done cycle: start again immediately.
    st16 = 1; a16 = 16'h8000; b16 = 16'h0001; ci16 = 0; sub16 = 1;
    @(posedge clk); #1;
    st16 = 0;
    check_bit("b2b busy", busy16, 1'b1);
    check_bit("b2b done_low", done16, 1'b0);
    lat = 0;
    while (!done16 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL b2b latency: got %0d expected 4", lat); end
    checks++;
    if (s16 !== 16'h7FFF) begin failures++; $display("FAIL b2b sum: got %h expected 7fff", s16); end
    check_bit("b2b carry", c16, 1'b1);
    check_bit("b2b overflow", v16, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit seen;
    run_op(16, 32'hFFFF, 32'hFFFF, 1, 0, "pre_reset");
    @(negedge clk);
    st16 = 1; a16 = 16'h1234; b16 = 16'h5678; ci16 = 0; sub16 = 0;
    @(posedge clk); #1;
    st16 = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check_bit("midreset busy", busy16, 1'b0);
    check_bit("midreset done", done16, 1'b0);
    check_bit("midreset carry", c16, 1'b0);
    check_bit("midreset overflow", v16, 1'b0);
    checks++;
    if (s16 !== 16'h0) begin failures++; $display("FAIL midreset sum: got %h expected 0000", s16); end
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (done16 || busy16) seen = 1; end
    check_bit("midreset no_done", seen, 1'b0);
  endtask

  task automatic test_full_chunk();
    run_op(8, 32'h9F, 32'h61, 0, 0, "w8_9f_61");
    run_op(8, 32'h7F, 32'h01, 0, 0, "w8_ovf");
    for (int i = 0; i < 10; i++) begin
      run_op(8, {24'd0, 8'($urandom)}, {24'd0, 8'($urandom)}, 1'($urandom), 1'($urandom),
             "rand8");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_full_chunk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
